// File: rtl/mcpu_ram_loader.sv
// Boot sequencer for MCPU: clears RAM, streams in a program image, then releases the CPU and hands it the RAM port.
// Optional build macro MCPU_LOAD_CHECKSUM_EN adds an XOR checksum of every loaded word.
module mcpu_ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MEMORY     = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   load_count
`ifdef MCPU_LOAD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(MEMORY - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH + 1)'(MEMORY - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;
  logic                  xfer;

  assign xfer       = (state_q == S_LOAD) && load_valid;
  assign load_count = load_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    load_count_d = load_count_q;
    case (state_q)
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == CLR_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          load_count_d = load_count_q + 1'b1;
          // A full RAM with no terminator is an overflow; the last slot is still written.
          if (load_last)                      state_d = S_RELEASE;
          else if (load_count_q == CNT_LAST) state_d = S_ERROR;
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN:     state_d = S_RUN;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_CLEAR;
    endcase
  end

  // Reset overrides the state decode so the reset cycle itself never writes RAM.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = clr_addr_q;
    ram_wdata  = '0;
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_CLEAR: ram_we = 1'b1;
        S_LOAD: begin
          load_ready = 1'b1;
          ram_we     = load_valid;
          ram_addr   = load_count_q[ADDR_WIDTH-1:0];
          ram_wdata  = load_data;
        end
        S_RUN: begin
          cpu_reset = 1'b0;
          done      = 1'b1;
          ram_we    = cpu_we;
          ram_addr  = cpu_addr;
          ram_wdata = cpu_wdata;
        end
        S_ERROR: error = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MCPU_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (xfer) checksum_d = checksum_q ^ load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
